// File: rtl/rs_pkg.sv
// Purpose : shared constants and GF(2^8) constant-multiply helpers for the RS syndrome stage.
// Contents: default code geometry (RS_N/RS_K), default field polynomial, xtime,
//           gf_mul_const (x * alpha^power) and alpha_pow (alpha^power).
package rs_pkg;

    localparam int          RS_N            = 204;
    localparam int          RS_K            = 188;
    localparam logic [8:0]  GF_POLY_DEFAULT = 9'h11D;

    // Multiply by alpha (0x02): shift left, reduce with the low byte of the polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [8:0] poly);
        logic [8:0] t;
        t = {x, 1'b0} ^ (x[7] ? poly : 9'h000);
        return t[7:0];
    endfunction

    // x * alpha^power. With a constant power this unrolls into a pure XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input int power,
                                                input logic [8:0] poly);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 255; i++) begin
            if (i < power) r = xtime(r, poly);
        end
        return r;
    endfunction

    function automatic logic [7:0] alpha_pow(input int power, input logic [8:0] poly);
        return gf_mul_const(8'h01, power, poly);
    endfunction

endpackage

// File: rtl/gf256_const_mul.sv
// Purpose : combinational GF(2^8) multiply by the constant alpha^POWER.
// Ports   : din (8b operand) -> dout (8b product); no clock, no state.
// Params  : POWER (exponent of alpha), GF_POLY (field generator polynomial).
module gf256_const_mul
    import rs_pkg::*;
#(
    parameter int         POWER   = 1,
    parameter logic [8:0] GF_POLY = GF_POLY_DEFAULT
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = gf_mul_const(din, POWER, GF_POLY);

endmodule

// File: rtl/rs_syndrome_calc.sv
// Purpose : byte-serial RS syndrome stage; Horner-evaluates S_j = r(alpha^j), j=0..N-K-1,
//           and holds each codeword's syndromes for the key-equation stage.
// Ports   : clk, reset (async, active high), CE/input_byte in; syn/syn_valid/syn_zero/
//           overrun out, syn_ack in. Macro RS_SYN_SOF_EN adds sof in and sync_err out.
// Timing  : results registered on the edge sampling byte N-1; one byte per clock, any CE pattern.
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int         N       = RS_N,
    parameter int         K       = RS_K,
    parameter logic [8:0] GF_POLY = GF_POLY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CE,
    input  logic [7:0]           input_byte,
    output logic [8*(N-K)-1:0]   syn,
    output logic                 syn_valid,
    input  logic                 syn_ack,
    output logic                 syn_zero,
    output logic                 overrun
`ifdef RS_SYN_SOF_EN
    ,
    input  logic                 sof,
    output logic                 sync_err
`endif
);

    localparam int         T2   = N - K;
    localparam logic [7:0] LAST = 8'(N - 1);

    logic [7:0]          cnt;
    logic [T2-1:0][7:0]  acc;
    logic [T2-1:0][7:0]  prod;
    logic [T2-1:0][7:0]  nxt;
    logic                sof_hit;
    logic                last;
    logic                capture;

    // One constant multiplier per syndrome; its output feeds both the running
    // update and the final capture, which differ only in where the result goes.
    for (genvar j = 0; j < T2; j++) begin : g_mul
        gf256_const_mul #(.POWER(j), .GF_POLY(GF_POLY)) u_mul (
            .din  (acc[j]),
            .dout (prod[j])
        );
        assign nxt[j] = prod[j] ^ input_byte;
    end

`ifdef RS_SYN_SOF_EN
    assign sof_hit = CE & sof;
`else
    assign sof_hit = 1'b0;
`endif

    assign last    = (cnt == LAST);
    // A forced start of frame discards the partial codeword, so it never captures.
    assign capture = CE & last & ~sof_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 8'd0;
            acc       <= '0;
            syn       <= '0;
            syn_valid <= 1'b0;
            syn_zero  <= 1'b0;
            overrun   <= 1'b0;
`ifdef RS_SYN_SOF_EN
            sync_err  <= 1'b0;
`endif
        end else begin
            if (CE) begin
                if (sof_hit || cnt == 8'd0) begin
                    acc <= {T2{input_byte}};
                    cnt <= 8'd1;
                end else begin
                    acc <= nxt;
                    cnt <= last ? 8'd0 : cnt + 8'd1;
                end
            end

            // Capture beats a same-cycle ack; an unacked result being replaced is an overrun.
            if (capture) begin
                syn       <= nxt;
                syn_zero  <= (nxt == '0);
                syn_valid <= 1'b1;
                if (syn_valid && !syn_ack) overrun <= 1'b1;
            end else if (syn_valid && syn_ack) begin
                syn_valid <= 1'b0;
            end

`ifdef RS_SYN_SOF_EN
            sync_err <= sof_hit && (cnt != 8'd0);
`endif
        end
    end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
module tb_rs_syndrome_calc;

    localparam int N  = 204;
    localparam int K  = 188;
    localparam int T2 = N - K;

    logic                clk = 1'b0;
    logic                reset;
    logic                CE;
    logic [7:0]          input_byte;
    logic [8*T2-1:0]     syn;
    logic                syn_valid;
    logic                syn_ack;
    logic                syn_zero;
    logic                overrun;
`ifdef RS_SYN_SOF_EN
    logic                sof;
    logic                sync_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]      blk [N];
    logic [7:0]      alog [255];
    logic [8*T2-1:0] exp_syn;
    logic            exp_zero;

    int  vcount = 0;
    bit  count_en = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) if (count_en && syn_valid) vcount++;

    rs_syndrome_calc #(.N(N), .K(K), .GF_POLY(9'h11D)) dut (
        .clk        (clk),
        .reset      (reset),
        .CE         (CE),
        .input_byte (input_byte),
        .syn        (syn),
        .syn_valid  (syn_valid),
        .syn_ack    (syn_ack),
        .syn_zero   (syn_zero),
        .overrun    (overrun)
`ifdef RS_SYN_SOF_EN
        ,
        .sof        (sof),
        .sync_err   (sync_err)
`endif
    );

    // Generic shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
        return p[7:0];
    endfunction

    // Reference: S_j = sum_i blk[i] * alpha^(j*(N-1-i)), evaluated directly as a polynomial.
    task automatic compute_expected();
        logic [7:0] s;
        exp_syn = '0;
        for (int j = 0; j < T2; j++) begin
            s = 8'h00;
            for (int i = 0; i < N; i++)
                s = s ^ gf_mul(blk[i], alog[(j * (N - 1 - i)) % 255]);
            exp_syn[8*j +: 8] = s;
        end
        exp_zero = (exp_syn == '0);
    endtask

    // Drives blk[] with `gap` idle cycles between bytes; leaves CE high on the last byte.
    task automatic feed(input int gap);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            CE = 1'b1;
            input_byte = blk[i];
            if (i < N - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    CE = 1'b0;
                end
            end
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) blk[i] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        CE = 1'b0;
        input_byte = 8'h00;
        syn_ack = 1'b0;
`ifdef RS_SYN_SOF_EN
        sof = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (syn_valid !== 1'b0 || syn_zero !== 1'b0 || overrun !== 1'b0 || syn !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b zero=%b overrun=%b syn=%h, required all 0",
                     syn_valid, syn_zero, overrun, syn);
        end
    endtask

    // Runs one block with ack held high and checks the one-cycle result pulse.
    task automatic run_checked(input string name, input int gap);
        syn_ack = 1'b1;
        compute_expected();
        feed(gap);
        @(negedge clk);
        CE = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || syn !== exp_syn || syn_zero !== exp_zero) begin
            errors++;
            $display("FAIL %s: valid=%b syn=%h zero=%b, required valid=1 syn=%h zero=%b",
                     name, syn_valid, syn, syn_zero, exp_syn, exp_zero);
        end
        @(negedge clk);
        checks++;
        if (syn_valid !== 1'b0 || syn !== exp_syn) begin
            errors++;
            $display("FAIL %s_ack: valid=%b syn=%h, required valid=0 syn held %h",
                     name, syn_valid, syn, exp_syn);
        end
    endtask

    task automatic test_zero_block();
        fill(8'h00);
        run_checked("zero_block", 0);
    endtask

    task automatic test_last_byte();
        fill(8'h00);
        blk[N-1] = 8'h5A;
        run_checked("last_byte", 0);
        checks++;
        if (syn !== {T2{8'h5A}}) begin
            errors++;
            $display("FAIL last_byte_const: syn=%h, required all 5a", syn);
        end
    endtask

    task automatic test_first_byte();
        fill(8'h00);
        blk[0] = 8'h01;
        run_checked("first_byte", 0);
        checks++;
        if (syn[7:0] !== 8'h01 || syn[15:8] !== alog[N-1]) begin
            errors++;
            $display("FAIL first_byte_s01: S0=%h S1=%h, required S0=01 S1=%h",
                     syn[7:0], syn[15:8], alog[N-1]);
        end
        run_checked("first_byte_gap7", 7);
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) blk[i] = 8'($urandom_range(0, 255));
            run_checked("random", b % 3);
        end
    endtask

    task automatic test_overrun();
        syn_ack = 1'b0;
        fill(8'h00);
        feed(0);
        @(negedge clk);
        CE = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || overrun !== 1'b0 || syn_zero !== 1'b1) begin
            errors++;
            $display("FAIL overrun_first: valid=%b overrun=%b zero=%b, required 1 0 1",
                     syn_valid, overrun, syn_zero);
        end
        blk[N-1] = 8'h11;
        feed(0);
        @(negedge clk);
        CE = 1'b0;
        checks++;
        if (syn_valid !== 1'b1 || overrun !== 1'b1 || syn !== {T2{8'h11}} || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL overrun_second: valid=%b overrun=%b zero=%b syn=%h, required 1 1 0 all 11",
                     syn_valid, overrun, syn_zero, syn);
        end
        syn_ack = 1'b1;
        @(negedge clk);
        syn_ack = 1'b0;
        checks++;
        if (syn_valid !== 1'b0 || overrun !== 1'b1 || syn !== {T2{8'h11}} || syn_zero !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: valid=%b overrun=%b zero=%b syn=%h, required 0 1 0 all 11",
                     syn_valid, overrun, syn_zero, syn);
        end
    endtask

    task automatic test_reset_mid();
        syn_ack = 1'b1;
        for (int i = 0; i < N; i++) blk[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            CE = 1'b1;
            input_byte = blk[i];
        end
        @(negedge clk);
        CE = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fill(8'h00);
        vcount = 0;
        count_en = 1'b1;
        feed(0);
        @(negedge clk);
        CE = 1'b0;
        repeat (3) @(negedge clk);
        count_en = 1'b0;
        checks++;
        if (vcount !== 1 || overrun !== 1'b0 || syn !== '0 || syn_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: pulses=%0d overrun=%b zero=%b syn=%h, required 1 0 1 zero",
                     vcount, overrun, syn_zero, syn);
        end
    endtask

`ifdef RS_SYN_SOF_EN
    task automatic test_sof();
        syn_ack = 1'b1;
        vcount = 0;
        count_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            CE = 1'b1;
            input_byte = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < N; i++) blk[i] = 8'($urandom_range(0, 255));
        compute_expected();
        @(negedge clk);
        CE = 1'b1;
        sof = 1'b1;
        input_byte = blk[0];
        @(negedge clk);
        sof = 1'b0;
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sof_err: sync_err=%b, required 1", sync_err);
        end
        input_byte = blk[1];
        @(negedge clk);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sof_pulse: sync_err=%b, required 0", sync_err);
        end
        for (int i = 2; i < N; i++) begin
            input_byte = blk[i];
            if (i < N - 1) @(negedge clk);
        end
        @(negedge clk);
        CE = 1'b0;
        checks++;
        if (vcount !== 1 || syn !== exp_syn || syn_zero !== exp_zero) begin
            errors++;
            $display("FAIL sof_block: pulses=%0d syn=%h zero=%b, required 1 syn=%h zero=%b",
                     vcount, syn, syn_zero, exp_syn, exp_zero);
        end
        count_en = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        alog[0] = 8'h01;
        for (int i = 1; i < 255; i++) alog[i] = gf_mul(alog[i-1], 8'h02);
        test_reset();
        test_zero_block();
        test_last_byte();
        test_first_byte();
        test_random();
        test_overrun();
        test_reset_mid();
`ifdef RS_SYN_SOF_EN
        test_sof();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
